// File: rtl/mic_pkg.sv
// Shared constants and FSM state type for the PmodMIC3 capture path.
package mic_pkg;

   localparam int FRAME_BITS     = 16;  // ADC frame length in SCLK periods
   localparam int LEAD_ZEROS     = 4;   // leading zero bits ahead of the sample
   localparam int DEFAULT_DATA_W = 12;  // ADC resolution
   localparam int BIT_CNT_W      = 5;   // wide enough to hold 0..FRAME_BITS-1

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      QUIET
   } mic_state_e;

endpackage

// File: rtl/mic_tick_gen.sv
// Conversion-rate tick generator: counts 0..SAMPLE_PERIOD-1 while enabled and
// flags the wrap cycle. The count is forced back to 0 while disabled, so the
// first tick lands SAMPLE_PERIOD cycles after enable rises.
module mic_tick_gen #(
   parameter int SAMPLE_PERIOD = 2268
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic start_tick
);

   localparam int CW = $clog2(SAMPLE_PERIOD);
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_PERIOD - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: advance while enabled, wrap at LAST, hold at 0 when disabled
   always_comb begin
      cnt_d = '0;
      if (enable && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
   end

   assign start_tick = enable && (cnt_q == LAST);

   // Counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pmod_mic3_reader.sv
// PmodMIC3 (ADCS7476-style) reader: periodic SPI conversion, 16-bit frame
// deserialisation, 12-bit sample on a valid/ready interface with overrun flag.
// Optional build macro MIC_SIGNED_EN: convert the offset-binary ADC code to
// two's complement by flipping the sample MSB. Timing is unchanged.
module pmod_mic3_reader
   import mic_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 2268,
   parameter int DATA_W        = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              miso,
   output logic              cs_n,
   output logic              sclk,
   output logic [DATA_W-1:0] sample_data,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic              overrun
);

   localparam logic [7:0]           DIV_LAST  = 8'(CLK_DIV - 1);
   localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(FRAME_BITS - 1);
   localparam logic [DATA_W-1:0]    SIGN_FLIP = {1'b1, {(DATA_W-1){1'b0}}};

   mic_state_e            state_q, state_d;
   logic [7:0]            div_q, div_d;
   logic [BIT_CNT_W-1:0]  bit_q, bit_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic                  cs_n_q, cs_n_d;
   logic                  sclk_q, sclk_d;
   logic [DATA_W-1:0]     data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  overrun_q, overrun_d;
   logic                  start_tick;
   logic                  load;
   logic [DATA_W-1:0]     raw;

   mic_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .start_tick (start_tick)
   );

   // Low DATA_W bits of the frame; the leading zero bits fall off the top.
   assign raw = shreg_q[DATA_W-1:0];

   // Next-state: conversion sequencing, SPI pins, shift register and handshake
   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      bit_d     = bit_q;
      shreg_d   = shreg_q;
      cs_n_d    = cs_n_q;
      sclk_d    = sclk_q;
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      load      = 1'b0;

      if (valid_q && sample_ready) valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b1;
            // ticks arriving in any other state are simply not looked at
            if (start_tick) begin
               state_d = SETUP;
               cs_n_d  = 1'b0;
               div_d   = '0;
            end
         end
         SETUP: begin
            if (div_q == DIV_LAST) begin
               state_d = SHIFT;
               sclk_d  = 1'b0;
               div_d   = '0;
               bit_d   = '0;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!sclk_q) begin
                  // rising SCLK edge: ADC data has been stable for the low phase
                  sclk_d  = 1'b1;
                  shreg_d = {shreg_q[FRAME_BITS-2:0], miso};
               end else if (bit_q == BIT_LAST) begin
                  state_d = QUIET;
                  cs_n_d  = 1'b1;
                  load    = 1'b1;
               end else begin
                  bit_d  = bit_q + 1'b1;
                  sclk_d = 1'b0;
               end
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         QUIET: begin
            if (div_q == DIV_LAST) begin
               state_d = IDLE;
               div_d   = '0;
            end else begin
               div_d = div_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A load wins over a same-cycle accept; overrun only if nobody took the old one
      if (load) begin
`ifdef MIC_SIGNED_EN
         data_d = raw ^ SIGN_FLIP;
`else
         data_d = raw;
`endif
         valid_d   = 1'b1;
         overrun_d = valid_q && !sample_ready;
      end
   end

   // State and output registers; reset forces the ADC deselected at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         cs_n_q    <= 1'b1;
         sclk_q    <= 1'b1;
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         cs_n_q    <= cs_n_d;
         sclk_q    <= sclk_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign cs_n         = cs_n_q;
   assign sclk         = sclk_q;
   assign sample_data  = data_q;
   assign sample_valid = valid_q;
   assign overrun      = overrun_q;

endmodule
